// File: rtl/board_status_panel.sv
// board_status_panel: shows a scrollable window of per-channel phases on the
// seven-segment digits and LEDs, with debounced keys, timed auto-scroll, an
// FT read-error indication and a heartbeat LED.
// Optional feature macro: PANEL_ERROR_COUNT_EN. When it is defined, the error
// indication is a saturating 8-bit pulse counter instead of a sticky bit.
module board_status_panel #(
  parameter int NUM_CHANNELS    = 4,
  parameter int PHASE_W         = 8,
  parameter int NUM_HEX         = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_PERIOD   = 50000000,
  parameter int HB_BIT          = 24,
  localparam int BASE_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                            sys_clk,
  input  logic                            ext_rst_n,
  input  logic [NUM_CHANNELS*PHASE_W-1:0] phases,
  input  logic                            read_error,
  input  logic                            key_next_n,
  input  logic                            key_prev_n,
  input  logic                            key_clr_n,
  input  logic                            auto_mode,
  output logic [NUM_HEX*7-1:0]            hex_seg,
  output logic [PHASE_W-1:0]              led_phase,
  output logic                            led_err,
  output logic                            led_hb,
  output logic [BASE_W-1:0]               win_base
);

  localparam int DPC   = (PHASE_W + 3) / 4;
  localparam int SLOTS = NUM_HEX / DPC;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int SC_W  = $clog2(SCROLL_PERIOD);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(SCROLL_PERIOD - 1);
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(NUM_CHANNELS - 1);

  // Bit order of synchroniser vectors: 0 next, 1 prev, 2 clear, 3 auto_mode.
  localparam logic [3:0] SYNC_RST = 4'b0111;

  // Active-low hex digit decode (bit 0 = segment a ... bit 6 = segment g).
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      4'hF:    seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [3:0]                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]                 deb_q, deb_d, press_q, press_d;
  logic [2:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic [SC_W-1:0]            scroll_q, scroll_d;
  logic [BASE_W-1:0]          base_q, base_d, base_nxt_s, base_prv_s;
  logic [NUM_HEX*7-1:0]       hex_q, hex_d;
  logic [PHASE_W-1:0]         led_phase_q, led_phase_d;
  logic [HB_BIT:0]            hb_q, hb_d;
  logic                       tc_s;
  int                         disp_ch_s;
  logic [DPC*4-1:0]           disp_pad_s;
`ifdef PANEL_ERROR_COUNT_EN
  logic [7:0]                 err_cnt_q, err_cnt_d;
  logic [PHASE_W+7:0]         err_cnt_ext_s;
`else
  logic                       err_q, err_d;
`endif

  // Two-stage synchronisers for the raw keys and the auto_mode switch.
  always_comb begin
    sync1_d = {auto_mode, key_clr_n, key_prev_n, key_next_n};
    sync2_d = sync1_q;
  end

  // Per-key debounce counters; a press is the flip of the debounced level to low.
  always_comb begin
    db_cnt_d = db_cnt_q;
    deb_d    = deb_q;
    press_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        deb_d[i]    = sync2_q[i];
        press_d[i]  = ~sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Scroll timer and window-base stepping; key presses outrank the timer.
  always_comb begin
    tc_s       = sync2_q[3] && (scroll_q == SC_LAST);
    base_nxt_s = (base_q == BASE_LAST) ? '0 : base_q + BASE_W'(1);
    base_prv_s = (base_q == '0) ? BASE_LAST : base_q - BASE_W'(1);
    if (!sync2_q[3]) begin
      scroll_d = '0;
    end else if ((|press_q) || tc_s) begin
      scroll_d = '0;
    end else begin
      scroll_d = scroll_q + SC_W'(1);
    end
    if (press_q[0] && press_q[1]) begin
      base_d = base_q;
    end else if (press_q[0]) begin
      base_d = base_nxt_s;
    end else if (press_q[1]) begin
      base_d = base_prv_s;
    end else if (tc_s) begin
      base_d = base_nxt_s;
    end else begin
      base_d = base_q;
    end
  end

  // Digit image of the window: slot k shows channel (base+k) mod NUM_CHANNELS.
  always_comb begin
    hex_d      = '1;
    disp_ch_s  = 0;
    disp_pad_s = '0;
    for (int k = 0; k < SLOTS; k++) begin
      disp_ch_s  = (int'(base_q) + k) % NUM_CHANNELS;
      disp_pad_s = '0;
      disp_pad_s[PHASE_W-1:0] = phases[disp_ch_s*PHASE_W +: PHASE_W];
      for (int j = 0; j < DPC; j++) begin
        hex_d[(k*DPC+j)*7 +: 7] = seg7(disp_pad_s[j*4 +: 4]);
      end
    end
  end

  // Error state and the phase LED (which may borrow the error count).
  always_comb begin
    hb_d = hb_q + (HB_BIT+1)'(1);
`ifdef PANEL_ERROR_COUNT_EN
    if (read_error && press_q[2]) begin
      err_cnt_d = 8'd1;
    end else if (read_error) begin
      err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
    end else if (press_q[2]) begin
      err_cnt_d = 8'd0;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    err_cnt_ext_s = {{PHASE_W{1'b0}}, err_cnt_q};
    if (!sync2_q[2] && deb_q[2]) begin
      led_phase_d = err_cnt_ext_s[PHASE_W-1:0];
    end else begin
      led_phase_d = phases[int'(base_q)*PHASE_W +: PHASE_W];
    end
`else
    if (read_error) begin
      err_d = 1'b1;
    end else if (press_q[2]) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    led_phase_d = phases[int'(base_q)*PHASE_W +: PHASE_W];
`endif
  end

  // All panel state; reset returns every register to its idle value.
  always_ff @(posedge sys_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      deb_q       <= 3'b111;
      press_q     <= 3'b000;
      db_cnt_q    <= '0;
      scroll_q    <= '0;
      base_q      <= '0;
      hex_q       <= '1;
      led_phase_q <= '0;
      hb_q        <= '0;
`ifdef PANEL_ERROR_COUNT_EN
      err_cnt_q   <= 8'd0;
`else
      err_q       <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      scroll_q    <= scroll_d;
      base_q      <= base_d;
      hex_q       <= hex_d;
      led_phase_q <= led_phase_d;
      hb_q        <= hb_d;
`ifdef PANEL_ERROR_COUNT_EN
      err_cnt_q   <= err_cnt_d;
`else
      err_q       <= err_d;
`endif
    end
  end

  assign hex_seg   = hex_q;
  assign led_phase = led_phase_q;
  assign led_hb    = hb_q[HB_BIT];
  assign win_base  = base_q;
`ifdef PANEL_ERROR_COUNT_EN
  assign led_err   = (err_cnt_q != 8'd0);
`else
  assign led_err   = err_q;
`endif

endmodule
